// File: rtl/line_fill_engine.sv
// line_fill_engine: refills one cache line from a narrower in-order memory as a burst of beats
//   Optional feature macro: LINE_FILL_BUFFER_EN (one-entry line buffer that answers repeat misses)
//   clk, rst             clock, synchronous active-high reset
//   i_line_addr_valid    cache requests a line
//   i_line_addr          requested line address
//   o_line_ready         single-cycle pulse, line delivered (combinational)
//   o_line_data          assembled line, word w at [w*DWIDTH +: DWIDTH]
//   o_mem_req_valid      beat read request
//   o_mem_req_addr       {saved line address, beat index}
//   i_mem_req_ready      memory accepts the request
//   i_mem_rsp_valid      beat data valid, no backpressure
//   i_mem_rsp_data       beat payload, responses in request order
module line_fill_engine #(
   parameter int DWIDTH = 5,
   parameter int BLOCK_WIDTH_BITS = 5,
   parameter int ADDR_IN_WIDTH = 20,
   parameter int BEAT_WORDS_BITS = 3,
   localparam int LINE_ADDR_WIDTH = ADDR_IN_WIDTH - BLOCK_WIDTH_BITS,
   localparam int LINE_WIDTH = DWIDTH * (2 ** BLOCK_WIDTH_BITS),
   localparam int BEAT_WIDTH = DWIDTH * (2 ** BEAT_WORDS_BITS),
   localparam int BEAT_SEL_BITS = BLOCK_WIDTH_BITS - BEAT_WORDS_BITS,
   localparam int NBEATS = 2 ** BEAT_SEL_BITS
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     i_line_addr_valid,
   input  logic [LINE_ADDR_WIDTH-1:0]               i_line_addr,
   output logic                                     o_line_ready,
   output logic [LINE_WIDTH-1:0]                    o_line_data,
   output logic                                     o_mem_req_valid,
   output logic [LINE_ADDR_WIDTH+BEAT_SEL_BITS-1:0] o_mem_req_addr,
   input  logic                                     i_mem_req_ready,
   input  logic                                     i_mem_rsp_valid,
   input  logic [BEAT_WIDTH-1:0]                    i_mem_rsp_data
);
   localparam int CW = BEAT_SEL_BITS + 1;
   localparam logic [CW-1:0] LAST = CW'(NBEATS - 1);
   localparam logic [CW-1:0] FULL = CW'(NBEATS);
   typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;
   state_t r_state, w_next;
   logic [LINE_ADDR_WIDTH-1:0] r_saved_addr;
   logic [CW-1:0] r_req_cnt, r_rsp_cnt;
   logic [LINE_WIDTH-1:0] r_line_data;
   logic w_hit, w_accept, w_req_fire, w_rsp_fire;
`ifdef LINE_FILL_BUFFER_EN
   logic r_buf_valid;
   logic [LINE_ADDR_WIDTH-1:0] r_buf_addr;
   // Every visit to S_DONE follows a completed fill, so the line in r_line_data is always whole.
   always_ff @(posedge clk)
      if (rst) begin
         r_buf_valid <= 1'b0;
         r_buf_addr <= '0;
      end else if (r_state == S_DONE) begin
         r_buf_valid <= 1'b1;
         r_buf_addr <= r_saved_addr;
      end
   assign w_hit = r_state == S_IDLE && i_line_addr_valid && r_buf_valid && i_line_addr == r_buf_addr;
`else
   assign w_hit = 1'b0;
`endif
   always_ff @(posedge clk)
      if (rst) r_state <= S_IDLE;
      else r_state <= w_next;
   always_comb begin
      w_accept = r_state == S_IDLE && i_line_addr_valid && !w_hit;
      o_mem_req_valid = r_state == S_FILL && r_req_cnt < FULL;
      o_mem_req_addr = {r_saved_addr, r_req_cnt[BEAT_SEL_BITS-1:0]};
      w_req_fire = o_mem_req_valid && i_mem_req_ready;
      // Responses outside S_FILL are protocol violations and are dropped here.
      w_rsp_fire = r_state == S_FILL && i_mem_rsp_valid;
      w_next = w_accept ? S_FILL :
               (w_rsp_fire && r_rsp_cnt == LAST) ? S_DONE :
               (r_state == S_DONE) ? S_IDLE : r_state;
      o_line_ready = w_hit || (r_state == S_DONE && i_line_addr_valid && i_line_addr == r_saved_addr);
   end
   always_ff @(posedge clk)
      if (rst) begin
         r_saved_addr <= '0;
         r_req_cnt <= '0;
         r_rsp_cnt <= '0;
         r_line_data <= '0;
      end else if (w_accept) begin
         r_saved_addr <= i_line_addr;
         r_req_cnt <= '0;
         r_rsp_cnt <= '0;
      end else begin
         if (w_req_fire) r_req_cnt <= r_req_cnt + CW'(1);
         if (w_rsp_fire) begin
            r_rsp_cnt <= r_rsp_cnt + CW'(1);
            r_line_data[int'(r_rsp_cnt[BEAT_SEL_BITS-1:0]) * BEAT_WIDTH +: BEAT_WIDTH] <= i_mem_rsp_data;
         end
      end
   assign o_line_data = r_line_data;
endmodule

// File: tb/tb_line_fill_engine.sv
// tb_line_fill_engine: scoreboard bench for line_fill_engine with an L=2 in-order memory model
module tb_line_fill_engine;
   localparam int LAW = 15, RAW = 17, LW = 160, BW = 40, L = 2;
   logic clk = 1'b0, rst = 1'b1;
   logic i_line_addr_valid = 1'b0;
   logic [LAW-1:0] i_line_addr = '0;
   logic o_line_ready;
   logic [LW-1:0] o_line_data;
   logic o_mem_req_valid;
   logic [RAW-1:0] o_mem_req_addr;
   logic i_mem_req_ready = 1'b1, i_mem_rsp_valid = 1'b0;
   logic [BW-1:0] i_mem_rsp_data = '0;
   int cyc = 0, checks = 0, errors = 0, last_rsp = -100;
   bit bp = 1'b0;
   typedef struct {int cyc; logic [RAW-1:0] addr;} req_t;
   typedef struct {int cyc; logic [LW-1:0] data;} line_t;
   typedef struct {int cyc; logic [BW-1:0] data;} rsp_t;
   req_t exp_req[$];
   line_t exp_line[$];
   rsp_t mem_q[$];
   req_t re;
   line_t le;
   int ec;

   line_fill_engine dut (
      .clk(clk), .rst(rst),
      .i_line_addr_valid(i_line_addr_valid), .i_line_addr(i_line_addr),
      .o_line_ready(o_line_ready), .o_line_data(o_line_data),
      .o_mem_req_valid(o_mem_req_valid), .o_mem_req_addr(o_mem_req_addr),
      .i_mem_req_ready(i_mem_req_ready), .i_mem_rsp_valid(i_mem_rsp_valid),
      .i_mem_rsp_data(i_mem_rsp_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [BW-1:0] beat(input logic [RAW-1:0] a);
      return {6'h2B, a, a};
   endfunction

   function automatic logic [LW-1:0] line_of(input logic [LAW-1:0] a);
      logic [LW-1:0] r;
      for (int b = 0; b < 4; b++) r[b*BW +: BW] = beat({a, 2'(b)});
      return r;
   endfunction

   task automatic chk(input string n, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", n, cyc, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Memory: drives ready and due responses at the start of each cycle.
   always @(posedge clk) begin
      #1;
      i_mem_req_ready = bp ? cyc[0] : 1'b1;
      if (mem_q.size() > 0 && mem_q[0].cyc == cyc) begin
         i_mem_rsp_valid = 1'b1;
         i_mem_rsp_data = mem_q[0].data;
         void'(mem_q.pop_front());
         last_rsp = cyc;
      end else begin
         i_mem_rsp_valid = 1'b0;
         i_mem_rsp_data = '0;
      end
   end

   // Monitor: samples mid-cycle, schedules memory responses and pops the scoreboard.
   always @(negedge clk) begin
      if (o_mem_req_valid && i_mem_req_ready) begin
         if (exp_req.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_mem_req cyc=%0d got=%0h expected=none", cyc, o_mem_req_addr);
         end else begin
            re = exp_req.pop_front();
            chk("mem_req_addr", LW'(o_mem_req_addr), LW'(re.addr));
            if (re.cyc >= 0) chk("mem_req_cycle", LW'(cyc), LW'(re.cyc));
         end
         if (!rst) mem_q.push_back('{cyc + L, beat(o_mem_req_addr)});
      end
      if (rst) mem_q.delete();
      if (o_line_ready) begin
         if (exp_line.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_line_ready cyc=%0d got=1 expected=0", cyc);
         end else begin
            le = exp_line.pop_front();
            ec = (le.cyc < 0) ? last_rsp + 1 : le.cyc;
            chk("line_data", o_line_data, le.data);
            chk("line_ready_cycle", LW'(cyc), LW'(ec));
         end
      end
   end

   task automatic fill(input logic [LAW-1:0] a, input bit hit, input bit timed);
      int t;
      bit seen;
      t = cyc;
      seen = 1'b0;
      i_line_addr_valid = 1'b1;
      i_line_addr = a;
      if (!hit)
         for (int b = 0; b < 4; b++) exp_req.push_back('{timed ? t + 1 + b : -1, {a, 2'(b)}});
      exp_line.push_back('{hit ? t : (timed ? t + 7 : -1), line_of(a)});
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         seen = o_line_ready;
         if (!seen) @(posedge clk);
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL line_ready_timeout addr=%0h got=none expected=pulse", a);
      end
      @(posedge clk);
      #1;
      i_line_addr_valid = 1'b0;
   endtask

   initial begin
      int t;
      tick(3);
      @(negedge clk);
      chk("reset_line_ready", LW'(o_line_ready), '0);
      chk("reset_mem_req_valid", LW'(o_mem_req_valid), '0);
      chk("reset_line_data", o_line_data, '0);
      tick(1);
      rst = 1'b0;
      tick(2);
      fill(15'h2A5, 1'b0, 1'b1);
      chk("first_line_beat0", LW'(o_line_data[39:0]), LW'({6'h2B, 17'hA94, 17'hA94}));
`ifdef LINE_FILL_BUFFER_EN
      fill(15'h2A5, 1'b1, 1'b1);
`else
      fill(15'h2A5, 1'b0, 1'b1);
`endif
      fill(15'h2A6, 1'b0, 1'b1);
      bp = 1'b1;
      fill(15'h133, 1'b0, 1'b0);
      bp = 1'b0;
      tick(2);
      t = cyc;
      i_line_addr_valid = 1'b1;
      i_line_addr = 15'h055;
      for (int b = 0; b < 4; b++) exp_req.push_back('{t + 1 + b, {15'h055, 2'(b)}});
      tick(2);
      i_line_addr_valid = 1'b0;
      tick(10);
      @(negedge clk);
      chk("drop_mem_req_valid", LW'(o_mem_req_valid), '0);
      chk("drop_line_ready", LW'(o_line_ready), '0);
      tick(1);
      t = cyc;
      i_line_addr_valid = 1'b1;
      i_line_addr = 15'h3C0;
      for (int b = 0; b < 4; b++) exp_req.push_back('{t + 1 + b, {15'h3C0, 2'(b)}});
      tick(4);
      rst = 1'b1;
      i_line_addr_valid = 1'b0;
      tick(1);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_mem_req_valid", LW'(o_mem_req_valid), '0);
      chk("rst_mid_line_ready", LW'(o_line_ready), '0);
      chk("rst_mid_line_data", o_line_data, '0);
      tick(1);
      fill(15'h001, 1'b0, 1'b1);
      tick(8);
      chk("exp_req_drained", LW'(exp_req.size()), '0);
      chk("exp_line_drained", LW'(exp_line.size()), '0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
